// File: rtl/core_inst_seq_if.sv
// Handshake and instruction-bus bundle between the kij-pass sequencer and the core/testbench.
// master = sequencer side, slave = the side that starts passes and consumes the instruction bus.
interface core_inst_seq_if;
  logic        start;
  logic [10:0] pmem_base;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;

  modport master (
    input  start, pmem_base, ofifo_valid,
    output inst, busy, done
  );

  modport slave (
    output start, pmem_base, ofifo_valid,
    input  inst, busy, done
  );
endinterface

// File: rtl/core_inst_seq.sv
// Instruction sequencer for one kij pass: weight fetch/load, activation fetch/execute, OFIFO drain.
// Every state word is registered so inst changes exactly on the edge that enters or advances a state.
module core_inst_seq #(
  parameter int          col     = 8,
  parameter int          row     = 8,
  parameter int          len_nij = 64,
  parameter int          gap     = 10,
  parameter logic [10:0] w_base  = 11'h400,
  parameter logic [10:0] x_base  = 11'h000
) (
  input logic             clk,
  input logic             reset,
  core_inst_seq_if.master bus
);

  localparam logic [33:0] IDLE_WORD = 34'h1800C0000;

  // Declaration order is the pass order; linear states advance by +1 when cnt expires.
  typedef enum logic [3:0] {
    S_IDLE, S_W_RD, S_W_TAIL, S_LD_PRE, S_LD, S_GAP1, S_X_RD, S_X_TAIL,
    S_EX_PRE, S_EX, S_GAP2, S_WAIT, S_OF_PRE, S_OF_WR, S_DONE
  } state_t;

  // row only describes the array; it is range-checked alongside the counted parameters.
  if (row < 1 || col < 1 || len_nij < 1 || gap < 1) begin : g_bad_param
    $error("core_inst_seq: row, col, len_nij and gap must all be >= 1");
  end

  state_t      state, nxt_state;
  logic [15:0] cnt;
  logic [10:0] addr, nxt_addr, pmem_q;
  logic [33:0] inst_q;
  logic        busy_q, done_q;
  logic        entering;

  // Value loaded into cnt on state entry: the state's cycle count minus one.
  function automatic logic [15:0] span_of(input state_t s);
    case (s)
      S_W_RD:         return 16'(col - 1);
      S_LD:           return 16'(2 * col - 1);
      S_GAP1, S_GAP2: return 16'(gap - 1);
      S_X_RD:         return 16'(len_nij - 1);
      S_EX, S_OF_WR:  return 16'(len_nij);
      default:        return 16'd0;
    endcase
  endfunction

  function automatic logic [33:0] word_of(input state_t s, input logic [10:0] a);
    logic [33:0] w;
    w = IDLE_WORD;
    case (s)
      S_W_RD, S_X_RD: begin
        w[19]   = 1'b0;
        w[17:7] = a;
        w[2]    = 1'b1;
      end
      S_W_TAIL, S_X_TAIL: w[2] = 1'b1;
      S_LD_PRE, S_EX_PRE: w[3] = 1'b1;
      S_LD: begin
        w[3] = 1'b1;
        w[0] = 1'b1;
      end
      S_EX: begin
        w[3] = 1'b1;
        w[1] = 1'b1;
      end
      S_OF_PRE: w[6] = 1'b1;
      S_OF_WR: begin
        w[6]     = 1'b1;
        w[32]    = 1'b0;
        w[31]    = 1'b0;
        w[30:20] = a;
      end
      default: ;
    endcase
    return w;
  endfunction

  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:  if (bus.start) nxt_state = S_W_RD;
      S_WAIT:  if (bus.ofifo_valid) nxt_state = S_OF_PRE;
      S_DONE:  nxt_state = S_IDLE;
      default: if (cnt == 16'd0) nxt_state = state_t'(state + 4'd1);
    endcase
    entering = (nxt_state != state);
    // One shared address register serves XMEM reads and psum writes; it wraps at 11 bits.
    nxt_addr = addr + 11'd1;
    if (entering) begin
      case (nxt_state)
        S_W_RD:  nxt_addr = w_base;
        S_X_RD:  nxt_addr = x_base;
        S_OF_WR: nxt_addr = pmem_q;
        default: nxt_addr = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      addr   <= '0;
      inst_q <= IDLE_WORD;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      addr   <= nxt_addr;
      cnt    <= entering ? span_of(nxt_state) : ((cnt == 16'd0) ? cnt : cnt - 16'd1);
      inst_q <= word_of(nxt_state, nxt_addr);
      busy_q <= (nxt_state != S_IDLE);
      done_q <= (nxt_state == S_DONE);
      if (state == S_IDLE && bus.start) pmem_q <= bus.pmem_base;
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Scoreboard bench for core_inst_seq: the expected per-cycle inst/busy/done stream of a pass
// is queued when start is driven and popped one entry per clock after each rising edge.
module tb_core_inst_seq;

  localparam logic [33:0] IDLE_W = 34'h1800C0000;
  localparam logic [6:0]  OFRD = 7'h40, L0RD = 7'h08, L0WR = 7'h04, EXE = 7'h02, LDB = 7'h01;

  logic clk = 1'b0;
  logic reset;

  core_inst_seq_if bus ();

  core_inst_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [33:0] inst;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  int   n_wr   = 0;

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] wd(input logic [6:0] strobes, input logic xrd,
                                     input logic [10:0] ax, input logic pwr,
                                     input logic [10:0] ap);
    logic [33:0] w;
    w      = IDLE_W;
    w[6:0] = strobes;
    if (xrd) begin
      w[19]   = 1'b0;
      w[17:7] = ax;
    end
    if (pwr) begin
      w[32]    = 1'b0;
      w[31]    = 1'b0;
      w[30:20] = ap;
    end
    return w;
  endfunction

  task automatic push(input logic [33:0] w, input logic b, input logic d, input int n);
    exp_t e;
    e.inst = w;
    e.busy = b;
    e.done = d;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Expected stream of one pass with default parameters; stall = extra WAIT cycles.
  task automatic build_pass(input logic [10:0] pb, input int stall);
    for (int i = 0; i < 8; i++) push(wd(L0WR, 1'b1, 11'h400 + 11'(i), 1'b0, 11'h0), 1'b1, 1'b0, 1);
    push(wd(L0WR, 1'b0, 11'h0, 1'b0, 11'h0), 1'b1, 1'b0, 1);
    push(wd(L0RD, 1'b0, 11'h0, 1'b0, 11'h0), 1'b1, 1'b0, 1);
    push(wd(L0RD | LDB, 1'b0, 11'h0, 1'b0, 11'h0), 1'b1, 1'b0, 16);
    push(IDLE_W, 1'b1, 1'b0, 10);
    for (int i = 0; i < 64; i++) push(wd(L0WR, 1'b1, 11'(i), 1'b0, 11'h0), 1'b1, 1'b0, 1);
    push(wd(L0WR, 1'b0, 11'h0, 1'b0, 11'h0), 1'b1, 1'b0, 1);
    push(wd(L0RD, 1'b0, 11'h0, 1'b0, 11'h0), 1'b1, 1'b0, 1);
    push(wd(L0RD | EXE, 1'b0, 11'h0, 1'b0, 11'h0), 1'b1, 1'b0, 65);
    push(IDLE_W, 1'b1, 1'b0, 10 + 1 + stall);
    push(wd(OFRD, 1'b0, 11'h0, 1'b0, 11'h0), 1'b1, 1'b0, 1);
    for (int i = 0; i < 65; i++) push(wd(OFRD, 1'b0, 11'h0, 1'b1, pb + 11'(i)), 1'b1, 1'b0, 1);
    push(IDLE_W, 1'b1, 1'b1, 1);
  endtask

  task automatic step_check(input string tag, input int k);
    exp_t  e;
    string t;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.inst = IDLE_W;
      e.busy = 1'b0;
      e.done = 1'b0;
    end
    t = $sformatf("%s[%0d]", tag, k);
    chk({t, ".inst"}, bus.inst, e.inst);
    chk({t, ".busy"}, 34'(bus.busy), 34'(e.busy));
    chk({t, ".done"}, 34'(bus.done), 34'(e.done));
    if (bus.done === 1'b1) n_done++;
    if (bus.inst[32] === 1'b0) n_wr++;
  endtask

  // k counts edges from E0 (the edge that samples start); pulses name the edge that samples start.
  task automatic run(input string tag, input logic [10:0] pb, input int stall, input int ncyc,
                     input int pulse_a, input int pulse_b, input int rst_at,
                     input int drop_lo, input int drop_hi);
    n_done          = 0;
    n_wr            = 0;
    reset           = 1'b1;
    bus.pmem_base   = pb;
    bus.start       = 1'b1;
    bus.ofifo_valid = (stall == 0);
    build_pass(pb, stall);
    for (int k = 0; k < ncyc; k++) begin
      step_check(tag, k);
      bus.start       = (k + 1 == pulse_a) || (k + 1 == pulse_b);
      bus.ofifo_valid = (stall == 0 || k >= 177 + stall) && !(k + 1 >= drop_lo && k + 1 <= drop_hi);
      if (k == rst_at) begin
        reset = 1'b0;
        exp_q.delete();
      end else begin
        reset = 1'b1;
      end
    end
    bus.start = 1'b0;
    chk({tag, ".queue_left"}, 34'(exp_q.size()), 34'd0);
  endtask

  initial begin
    reset           = 1'b0;
    bus.start       = 1'b1;
    bus.pmem_base   = 11'h0;
    bus.ofifo_valid = 1'b1;
    for (int k = 0; k < 3; k++) step_check("reset", k);
    reset     = 1'b1;
    bus.start = 1'b0;
    step_check("post_reset", 0);

    run("pass", 11'h001, 0, 250, -1, -1, -1, -1, -1);
    chk("pass.done_count", 34'(n_done), 34'd1);
    chk("pass.wr_count", 34'(n_wr), 34'd65);

    run("stall", 11'h001, 20, 270, -1, -1, -1, -1, -1);
    chk("stall.done_count", 34'(n_done), 34'd1);
    chk("stall.wr_count", 34'(n_wr), 34'd65);

    run("wrap", 11'h7F0, 0, 250, -1, -1, -1, 185, 190);
    chk("wrap.done_count", 34'(n_done), 34'd1);
    chk("wrap.wr_count", 34'(n_wr), 34'd65);

    run("midrst", 11'h001, 0, 140, -1, -1, 131, -1, -1);
    chk("midrst.done_count", 34'(n_done), 34'd0);
    chk("midrst.wr_count", 34'(n_wr), 34'd0);

    run("restart", 11'h010, 0, 250, -1, -1, -1, -1, -1);
    chk("restart.done_count", 34'(n_done), 34'd1);

    run("ignore", 11'h005, 0, 252, 121, 245, -1, -1, -1);
    chk("ignore.done_count", 34'(n_done), 34'd1);
    chk("ignore.wr_count", 34'(n_wr), 34'd65);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/core_inst_seq.md
# core_inst_seq

Hardware instruction sequencer that drives the core's 34-bit `inst` bus for one complete kij pass. It replaces bench-driven stimulus in the full-chip flow: it sits beside `core`, issues one pass on each `start` pulse, and reports completion with `done`. The pass has five phases: weight fetch to L0, weight load into the PEs, activation fetch to L0, execute, and OFIFO drain into psum SRAM.

## Interface
- `col`, 8: PE columns; weight rows fetched per pass.
- `row`, 8: PE rows (informational; sets no counter widths here).
- `len_nij`, 64: activation vectors per pass.
- `gap`, 10: idle intermission cycles after the load phase and after the execute phase.
- `w_base`, 11'h400: XMEM address of weight row 0.
- `x_base`, 11'h000: XMEM address of activation 0.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `start` in 1: begin a pass; sampled only in IDLE.
- `pmem_base` in 11: psum SRAM start address; latched when `start` is accepted.
- `ofifo_valid` in 1: the core's OFIFO has data.
- `inst` out 34: instruction bus, registered.
  - [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- `busy` out 1: a pass is in progress.
- `done` out 1: one-cycle pulse at the end of a pass.

## Operation
- IDLE word: CEN/WEN of both SRAMs = 1, all other bits 0, i.e. `inst` = 34'h1800C0000.
- Every bit not listed for a state holds its IDLE value. `acc`, `ififo_wr`, `ififo_rd` and `WEN_xmem` are never driven low/high away from IDLE (XMEM is read-only here).
- One down-counter `cnt` is loaded on every state entry.
- States, in order, with cycle count and driven bits:
  - IDLE: `start`=1 is accepted → W_RD. `pmem_base` is latched.
  - W_RD (`col` cycles): CEN_xmem=0, A_xmem = w_base + i, l0_wr=1.
  - W_TAIL (1 cycle): CEN_xmem=1, l0_wr=1. This captures the last SRAM read, which has 1-cycle latency.
  - LD_PRE (1 cycle): l0_rd=1.
  - LD (2·`col` cycles): l0_rd=1, load=1.
  - GAP1 (`gap` cycles): IDLE word.
  - X_RD (`len_nij` cycles): CEN_xmem=0, A_xmem = x_base + i, l0_wr=1.
  - X_TAIL (1 cycle): l0_wr=1.
  - EX_PRE (1 cycle): l0_rd=1.
  - EX (`len_nij`+1 cycles): l0_rd=1, execute=1.
  - GAP2 (`gap` cycles): IDLE word.
  - WAIT (≥1 cycle): IDLE word; advances when `ofifo_valid`=1.
  - OF_PRE (1 cycle): ofifo_rd=1.
  - OF_WR (`len_nij`+1 cycles): ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem = pmem_base + i.
  - DONE (1 cycle): IDLE word, `done`=1 → IDLE.
- Address arithmetic is 11-bit and wraps modulo 2048 (e.g. pmem_base=11'h7FF gives A_pmem 7FF, 000, 001, …).
- `start` is ignored while `busy`=1; it is not queued.
- `ofifo_valid` is ignored outside WAIT. A drop during OF_WR does not stall the drain.

## Timing
- Reset (reset=0 at an edge): state returns to IDLE. `inst`=34'h1800C0000, `busy`=0, `done`=0, counters cleared. This takes effect even mid-pass and aborts the pass with no further SRAM or FIFO strobes.
- `inst` is registered. At the edge that samples `start`=1 (E0), `inst` takes the first W_RD word; each state word then holds for exactly one cycle per listed count.
- `busy` rises with the first W_RD word and stays 1 through the DONE cycle. It drops together with `done`.
- The cycle count before WAIT is fixed at 177 with defaults. With `ofifo_valid` already 1, `done` is presented after edge E0+244.
- A back-to-back pass is possible: `start`=1 during DONE is ignored. `start`=1 in the next (IDLE) cycle is accepted.

## Test plan
- Reset: hold reset=0 for 3 cycles with `start`=1 → `inst`=34'h1800C0000, `busy`=0, `done`=0 throughout.
- Full pass, defaults, `ofifo_valid` tied 1, pmem_base=1:
  - exactly 8 words with CEN_xmem=0, A_xmem 400..407, then 16 load=1 cycles;
  - 64 activation reads at 000..03F, then 65 execute=1 cycles;
  - 65 psum writes at A_pmem 001..041;
  - `done` after E0+244, one cycle wide.
- WAIT stall: hold `ofifo_valid`=0 for 20 cycles after GAP2 → `inst` stays idle for 20 cycles, and `done` moves to E0+264.
- Wrap: pmem_base=11'h7F0 → A_pmem runs 7F0..7FF, then 000..030; the write count is still 65.
- Mid-pass reset at the 30th EX cycle → the next `inst` is the idle word, `busy`=0, and no further strobes appear. A following `start` restarts from W_RD at A_xmem 400.
- `start` pulsed during EX and again during DONE → both ignored; exactly one `done` pulse occurs.
